// File: rtl/relay_alu_pkg.sv
// Shared types and constants for the relay-computer ALU result stage.
// Function codes follow the front-panel encoding used by the gate array.
package relay_alu_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD = 3'b000,
    FUNC_INC = 3'b001,
    FUNC_AND = 3'b010,
    FUNC_OR  = 3'b011,
    FUNC_XOR = 3'b100,
    FUNC_NOT = 3'b101,
    FUNC_SHL = 3'b110,
    FUNC_CLR = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2
  } alu_state_e;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_D = 1'b1;

  // Wide enough for the largest legal settle delay (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_result_stage_if.sv
// Request/operand/result bundle between the gate array, sequencer and the
// ALU result stage.
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);
  import relay_alu_pkg::*;

  logic             req;
  alu_func_e        func;
  logic             dest;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] and_in;
  logic [WIDTH-1:0] or_in;
  logic [WIDTH-1:0] xor_in;
  logic [WIDTH-1:0] not_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_sign;

  modport master (
    output req, func, dest, b, c, and_in, or_in, xor_in, not_in,
    input  busy, done, a_reg, d_reg, flag_zero, flag_carry, flag_sign
  );

  modport slave (
    input  req, func, dest, b, c, and_in, or_in, xor_in, not_in,
    output busy, done, a_reg, d_reg, flag_zero, flag_carry, flag_sign
  );

endinterface

// File: rtl/alu_result_mux.sv
// Combinational result/carry selection from the captured operands.
// Adder, incrementer and shifter are formed here; logic ops pass through.
module alu_result_mux
  import relay_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_func_e        func,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] and_in,
  input  logic [WIDTH-1:0] or_in,
  input  logic [WIDTH-1:0] xor_in,
  input  logic [WIDTH-1:0] not_in,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum_add;
  logic [WIDTH:0] sum_inc;

  assign sum_add = {1'b0, b} + {1'b0, c};
  assign sum_inc = {1'b0, b} + (WIDTH+1)'(1);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (func)
      FUNC_ADD: begin
        result = sum_add[WIDTH-1:0];
        carry  = sum_add[WIDTH];
      end
      FUNC_INC: begin
        result = sum_inc[WIDTH-1:0];
        carry  = sum_inc[WIDTH];
      end
      FUNC_AND: result = and_in;
      FUNC_OR:  result = or_in;
      FUNC_XOR: result = xor_in;
      FUNC_NOT: result = not_in;
      FUNC_SHL: begin
        result = {b[WIDTH-2:0], 1'b0};
        carry  = b[WIDTH-1];
      end
      FUNC_CLR: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Relay ALU result stage: latches operands on request, waits out the relay
// settle time, then writes the selected result into A or D with flags.
module alu_result_stage
  import relay_alu_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  alu_result_stage_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;

  alu_func_e        func_q, func_d;
  logic             dest_q, dest_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] and_q, and_d;
  logic [WIDTH-1:0] or_q, or_d;
  logic [WIDTH-1:0] xor_q, xor_d;
  logic [WIDTH-1:0] not_q, not_d;

  logic [WIDTH-1:0] result;
  logic             carry;

  alu_result_mux #(.WIDTH(WIDTH)) u_mux (
    .func   (func_q),
    .b      (b_q),
    .c      (c_q),
    .and_in (and_q),
    .or_in  (or_q),
    .xor_in (xor_q),
    .not_in (not_q),
    .result (result),
    .carry  (carry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    areg_d  = areg_q;
    dreg_d  = dreg_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    func_d  = func_q;
    dest_d  = dest_q;
    b_d     = b_q;
    c_d     = c_q;
    and_d   = and_q;
    or_d    = or_q;
    xor_d   = xor_q;
    not_d   = not_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
          func_d  = bus.func;
          dest_d  = bus.dest;
          b_d     = bus.b;
          c_d     = bus.c;
          and_d   = bus.and_in;
          or_d    = bus.or_in;
          xor_d   = bus.xor_in;
          not_d   = bus.not_in;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_WRITE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (dest_q == DEST_D) dreg_d = result;
        else                  areg_d = result;
        zero_d  = (result == '0);
        carry_d = carry;
        sign_d  = result[WIDTH-1];
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy stays up through the cycle in which the write becomes visible.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      areg_q  <= '0;
      dreg_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      areg_q  <= areg_d;
      dreg_q  <= dreg_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
    end
  end

  // Operand latches are only read after a capture, so they need no reset.
  always_ff @(posedge clk) begin
    func_q <= func_d;
    dest_q <= dest_d;
    b_q    <= b_d;
    c_q    <= c_d;
    and_q  <= and_d;
    or_q   <= or_d;
    xor_q  <= xor_d;
    not_q  <= not_d;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.a_reg      = areg_q;
  assign bus.d_reg      = dreg_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_sign  = sign_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table, corner-case sequences and
// randomized operations against an arithmetic reference model.
module tb_alu_result_stage;
  import relay_alu_pkg::*;

  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] a_exp = 8'h00;
  logic [7:0] d_exp = 8'h00;
  logic       z_exp = 1'b0;
  logic       c_exp = 1'b0;
  logic       s_exp = 1'b0;

  typedef struct {
    logic [2:0] f;
    logic       dst;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] r;
    logic       z;
    logic       cy;
    logic       s;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [2:0] f, input logic dst, input logic [7:0] b, input logic [7:0] c);
    bus.func   = alu_func_e'(f);
    bus.dest   = dst;
    bus.b      = b;
    bus.c      = c;
    bus.and_in = b & c;
    bus.or_in  = b | c;
    bus.xor_in = b ^ c;
    bus.not_in = ~b;
  endtask

  // Reference: plain integer arithmetic, carry = anything past 8 bits.
  function automatic void ref_model(input logic [2:0] f, input logic [7:0] b, input logic [7:0] c,
                                    output logic [7:0] r, output logic cy);
    int v;
    case (f)
      3'd0:    v = int'(b) + int'(c);
      3'd1:    v = int'(b) + 1;
      3'd2:    v = int'(b & c);
      3'd3:    v = int'(b | c);
      3'd4:    v = int'(b ^ c);
      3'd5:    v = 255 - int'(b);
      3'd6:    v = int'(b) * 2;
      default: v = 0;
    endcase
    r  = 8'(v % 256);
    cy = (v > 255);
  endfunction

  task automatic check_state(input string tag);
    check({tag, " a_reg"}, 32'(bus.a_reg), 32'(a_exp));
    check({tag, " d_reg"}, 32'(bus.d_reg), 32'(d_exp));
    check({tag, " zero"},  32'(bus.flag_zero), 32'(z_exp));
    check({tag, " carry"}, 32'(bus.flag_carry), 32'(c_exp));
    check({tag, " sign"},  32'(bus.flag_sign), 32'(s_exp));
  endtask

  task automatic apply_expect(input logic dst, input logic [7:0] r, input logic z,
                              input logic cy, input logic s);
    if (dst) d_exp = r;
    else     a_exp = r;
    z_exp = z;
    c_exp = cy;
    s_exp = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    a_exp = 8'h00; d_exp = 8'h00;
    z_exp = 1'b0;  c_exp = 1'b0; s_exp = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic dst,
                        input logic [7:0] b, input logic [7:0] c, input bit scramble,
                        input logic [7:0] r, input logic z, input logic cy, input logic s);
    int lat;
    bit busy_ok;
    @(negedge clk);
    drive_ops(f, dst, b, c);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    check({tag, " busy at start"}, 32'(bus.busy), 32'd1);
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (scramble)
        drive_ops(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, " done latency"}, 32'(lat), 32'(S + 1));
    check({tag, " busy held"}, 32'(busy_ok), 32'd1);
    apply_expect(dst, r, z, cy, s);
    check_state(tag);
    @(posedge clk);
    #1;
    check({tag, " busy after"}, 32'(bus.busy), 32'd0);
    check({tag, " done after"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rr;
    logic       rc;
    bit         ok;
    int         t, idx, last;
    logic [2:0] bf[3];
    logic       bd[3];
    logic [7:0] bb[3];
    logic [7:0] br[3];
    logic       bz[3], bc[3], bs[3];

    tbl[0] = '{3'd0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{3'd4, 1'b1, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{3'd6, 1'b1, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'd3, 1'b1, 8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{3'd5, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{3'd1, 1'b1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{3'd0, 1'b0, 8'h40, 8'h3F, 8'h7F, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{3'd7, 1'b1, 8'h5A, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{3'd6, 1'b0, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};

    reset   = 1'b1;
    bus.req = 1'b0;
    drive_ops(3'd0, 1'b0, 8'h00, 8'h00);

    // Reset, then idle with no request.
    do_reset();
    check_state("reset");
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done || bus.a_reg != 8'h00 || bus.d_reg != 8'h00 ||
          bus.flag_zero || bus.flag_carry || bus.flag_sign) ok = 1'b0;
    end
    check("idle outputs stable", 32'(ok), 32'd1);

    // Table of directed vectors; odd entries scramble inputs while busy.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].dst, tbl[i].b, tbl[i].c, (i % 2) == 1,
             tbl[i].r, tbl[i].z, tbl[i].cy, tbl[i].s);

    // Reset in the second SETTLE cycle aborts the ADD.
    do_reset();
    @(negedge clk);
    drive_ops(3'd0, 1'b0, 8'h10, 8'h20);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check_state("abort");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.a_reg != 8'h00 || bus.flag_zero || bus.flag_carry) ok = 1'b0;
    end
    check("abort no write", 32'(ok), 32'd1);
    run_op("inc after abort", 3'd1, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);

    // Back-to-back with req held high: CLR->A, NOT 0x00->D, INC 0xFF->A.
    bf = '{3'd7, 3'd5, 3'd1};
    bd = '{1'b0, 1'b1, 1'b0};
    bb = '{8'h33, 8'h00, 8'hFF};
    br = '{8'h00, 8'hFF, 8'h00};
    bz = '{1'b1, 1'b0, 1'b1};
    bc = '{1'b0, 1'b0, 1'b1};
    bs = '{1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive_ops(bf[0], bd[0], bb[0], 8'h00);
    bus.req = 1'b1;
    t = 0; idx = 0; last = 0;
    while (idx < 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
      if (bus.done) begin
        if (idx > 0) check($sformatf("b2b spacing %0d", idx), 32'(t - last), 32'(S + 2));
        last = t;
        apply_expect(bd[idx], br[idx], bz[idx], bc[idx], bs[idx]);
        check_state($sformatf("b2b op%0d", idx));
        idx++;
        if (idx < 3) drive_ops(bf[idx], bd[idx], bb[idx], 8'h00);
        else         bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    check("b2b ops completed", 32'(idx), 32'd3);
    @(posedge clk);
    #1;
    check("b2b idle busy", 32'(bus.busy), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0] f;
      logic       dst;
      logic [7:0] b, c;
      f   = 3'($urandom_range(0, 7));
      dst = 1'($urandom_range(0, 1));
      b   = 8'($urandom);
      c   = 8'($urandom);
      ref_model(f, b, c, rr, rc);
      run_op($sformatf("rand%0d f%0d", i, f), f, dst, b, c, 1'($urandom_range(0, 1)),
             rr, (rr == 8'h00), rc, rr[7]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
